// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC sequencing controller: fetch/decode/exec FSM with exception save, vector and halt
//
// Ports:
//   clk             in   clock, all state updates on rising edge
//   reset           in   asynchronous active-low reset
//   mem_ready       in   instruction memory holds a valid word this cycle
//   op_class        in   decoder class (seq/branch/jump/jr/rte, 101-111 invalid)
//   branch_taken    in   ALU compare result, meaningful in EXEC
//   overflow        in   ALU overflow, meaningful in EXEC
//   PcSourceControl out  next-PC select: 00 jump target, 01 ALU result, 10 ALUOut, 11 EPC
//   PCWrite         out  PC load enable
//   IRWrite         out  instruction register load enable
//   EPCWrite        out  EPC load enable
//   VecSel          out  steers exception vector constant onto ALU result
//   ExcCause        out  registered cause: 00 none, 01 invalid op, 10 overflow, 11 fetch timeout
//   halted          out  double-fault stop indication

module pc_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic [2:0] op_class,
    input  logic       branch_taken,
    input  logic       overflow,
    output logic [1:0] PcSourceControl,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       EPCWrite,
    output logic       VecSel,
    output logic [1:0] ExcCause,
    output logic       halted
);

    localparam logic [2:0] OP_SEQ    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;
    localparam logic [2:0] OP_RTE    = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam logic [1:0] SRC_JUMP = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_OUT  = 2'b10;
    localparam logic [1:0] SRC_EPC  = 2'b11;

    localparam logic [3:0] WAIT_LAST = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_EXC_SAVE = 3'd3,
        S_EXC_VEC  = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       in_exc_q, in_exc_d;
    logic [1:0] cause_q, cause_d;
    logic [2:0] op_q, op_d;

    logic       exc_req;
    logic [1:0] exc_code;

    logic [1:0] src_c;
    logic       pcw_c, irw_c, epcw_c, vec_c, halt_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            wait_q   <= 4'd0;
            in_exc_q <= 1'b0;
            cause_q  <= CAUSE_NONE;
            op_q     <= OP_SEQ;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            in_exc_q <= in_exc_d;
            cause_q  <= cause_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        in_exc_d = in_exc_q;
        cause_d  = cause_q;
        op_d     = op_q;
        exc_req  = 1'b0;
        exc_code = CAUSE_NONE;
        src_c    = 2'b00;
        pcw_c    = 1'b0;
        irw_c    = 1'b0;
        epcw_c   = 1'b0;
        vec_c    = 1'b0;
        halt_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    src_c   = SRC_ALU;
                    wait_d  = 4'd0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    // Sixteenth consecutive stalled cycle: give up on memory.
                    wait_d   = 4'd0;
                    exc_req  = 1'b1;
                    exc_code = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            S_DECODE: begin
                op_d = op_class;
                if (op_class > OP_RTE) begin
                    exc_req  = 1'b1;
                    exc_code = CAUSE_INVALID;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_SEQ: begin
                        // Only sequential ALU ops can trap on overflow.
                        if (overflow) begin
                            exc_req  = 1'b1;
                            exc_code = CAUSE_OVF;
                        end
                    end
                    OP_BRANCH: begin
                        src_c = SRC_OUT;
                        pcw_c = branch_taken;
                    end
                    OP_JUMP: begin
                        src_c = SRC_JUMP;
                        pcw_c = 1'b1;
                    end
                    OP_JR: begin
                        src_c = SRC_ALU;
                        pcw_c = 1'b1;
                    end
                    OP_RTE: begin
                        src_c    = SRC_EPC;
                        pcw_c    = 1'b1;
                        in_exc_d = 1'b0;
                        cause_d  = CAUSE_NONE;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_EXC_SAVE: begin
                epcw_c   = 1'b1;
                in_exc_d = 1'b1;
                state_d  = S_EXC_VEC;
            end

            S_EXC_VEC: begin
                vec_c   = 1'b1;
                src_c   = SRC_ALU;
                pcw_c   = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT: begin
                halt_c = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A second fault while still servicing the first cannot save EPC
        // without losing the original return address, so stop instead.
        if (exc_req) begin
            cause_d = exc_code;
            state_d = in_exc_q ? S_HALT : S_EXC_SAVE;
        end
    end

    // Outputs are forced low while reset is held so nothing pulses during
    // the asynchronous reset window, even though FETCH would otherwise decode.
    always_comb begin
        PcSourceControl = 2'b00;
        PCWrite         = 1'b0;
        IRWrite         = 1'b0;
        EPCWrite        = 1'b0;
        VecSel          = 1'b0;
        halted          = 1'b0;
        if (reset) begin
            PcSourceControl = src_c;
            PCWrite         = pcw_c;
            IRWrite         = irw_c;
            EPCWrite        = epcw_c;
            VecSel          = vec_c;
            halted          = halt_c;
        end
    end

    assign ExcCause = cause_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed self-checking bench for pc_seq_ctrl

module tb_pc_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       mem_ready;
    logic [2:0] op_class;
    logic       branch_taken;
    logic       overflow;
    logic [1:0] PcSourceControl;
    logic       PCWrite;
    logic       IRWrite;
    logic       EPCWrite;
    logic       VecSel;
    logic [1:0] ExcCause;
    logic       halted;

    int checks = 0;
    int errors = 0;

    pc_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .mem_ready      (mem_ready),
        .op_class       (op_class),
        .branch_taken   (branch_taken),
        .overflow       (overflow),
        .PcSourceControl(PcSourceControl),
        .PCWrite        (PCWrite),
        .IRWrite        (IRWrite),
        .EPCWrite       (EPCWrite),
        .VecSel         (VecSel),
        .ExcCause       (ExcCause),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [2:0] op, input logic bt, input logic ov);
        mem_ready    = mr;
        op_class     = op;
        branch_taken = bt;
        overflow     = ov;
        #1;
    endtask

    // Output vector: {halted, ExcCause, VecSel, EPCWrite, IRWrite, PCWrite, PcSourceControl}
    task automatic expect_out(input string tag, input logic [1:0] src, input logic pcw,
                              input logic irw, input logic epcw, input logic vec,
                              input logic [1:0] cause, input logic hlt);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {halted, ExcCause, VecSel, EPCWrite, IRWrite, PCWrite, PcSourceControl};
        exp = {hlt, cause, vec, epcw, irw, pcw, src};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // FETCH cycle with memory ready, then DECODE of the given class.
    task automatic pass_fd(input string tag, input logic [2:0] op, input logic [1:0] cause);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out({tag, "_fetch"}, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, cause, 1'b0);
        tick();
        drive(1'b1, op, 1'b0, 1'b0);
        expect_out({tag, "_decode"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, cause, 1'b0);
        tick();
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!(PCWrite === 1'b1 && EPCWrite === 1'b1)) else begin
            errors++;
            $error("FAIL pcw_epcw_exclusive observed=%b%b expected=not 11", PCWrite, EPCWrite);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 3'b111, 1'b1, 1'b1);
        expect_out("rst_hold", 2'b00, 0, 0, 0, 0, 2'b00, 0);

        // Normal sequential stream: fetch once every three cycles.
        reset = 1'b1;
        pass_fd("seq1", 3'b000, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("seq1_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        pass_fd("seq2", 3'b000, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("seq2_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();

        pass_fd("br_t", 3'b001, 2'b00);
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        expect_out("br_taken", 2'b10, 1, 0, 0, 0, 2'b00, 0);
        tick();

        pass_fd("br_n", 3'b001, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        expect_out("br_not_taken", 2'b10, 0, 0, 0, 0, 2'b00, 0);
        tick();

        pass_fd("jmp", 3'b010, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("jump_exec", 2'b00, 1, 0, 0, 0, 2'b00, 0);
        tick();

        pass_fd("jr", 3'b011, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        expect_out("jr_exec_ovf_ignored", 2'b01, 1, 0, 0, 0, 2'b00, 0);
        tick();

        // Overflow trap.
        pass_fd("ovf", 3'b000, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        expect_out("ovf_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("ovf_save", 2'b00, 0, 0, 1, 0, 2'b10, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("ovf_vec", 2'b01, 1, 0, 0, 1, 2'b10, 0);
        tick();

        // Return from exception clears the cause and the in-exception flag.
        pass_fd("rte", 3'b100, 2'b10);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("rte_exec", 2'b11, 1, 0, 0, 0, 2'b10, 0);
        tick();
        pass_fd("ovf2", 3'b000, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        expect_out("ovf2_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("ovf2_save", 2'b00, 0, 0, 1, 0, 2'b10, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("ovf2_vec", 2'b01, 1, 0, 0, 1, 2'b10, 0);
        tick();

        // Invalid op while in exception: double fault to HALT.
        pass_fd("dbl", 3'b111, 2'b10);
        drive(1'b1, 3'b000, 1'b1, 1'b1);
        expect_out("halt_entry", 2'b00, 0, 0, 0, 0, 2'b01, 1);
        tick();
        drive(1'b1, 3'b100, 1'b1, 1'b0);
        expect_out("halt_stay", 2'b00, 0, 0, 0, 0, 2'b01, 1);
        reset = 1'b0;
        #1;
        expect_out("halt_async_rst", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();

        // Memory ready on the last allowed stalled cycle: normal fetch.
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0);
            expect_out("stall15", 2'b00, 0, 0, 0, 0, 2'b00, 0);
            tick();
        end
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("late_ready", 2'b01, 1, 1, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("late_decode", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("late_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();

        // Sixteen stalled cycles: fetch timeout.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b0);
            expect_out("stall16", 2'b00, 0, 0, 0, 0, 2'b00, 0);
            tick();
        end
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("tmo_save", 2'b00, 0, 0, 1, 0, 2'b11, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("tmo_vec", 2'b01, 1, 0, 0, 1, 2'b11, 0);
        tick();

        // Reset in the middle of EXC_SAVE aborts it.
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        pass_fd("inv", 3'b101, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("inv_save", 2'b00, 0, 0, 1, 0, 2'b01, 0);
        reset = 1'b0;
        #1;
        expect_out("save_async_rst", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("save_rst_held", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        reset = 1'b1;
        pass_fd("post_rst", 3'b000, 2'b00);
        drive(1'b1, 3'b000, 1'b0, 1'b1);
        expect_out("post_rst_exec", 2'b00, 0, 0, 0, 0, 2'b00, 0);
        tick();
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        expect_out("post_rst_save_not_halt", 2'b00, 0, 0, 1, 0, 2'b10, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
